// File: rtl/cpu_coalescing_storebuffer.sv
// +--------------------------------------------------------------------------+
// | Module   : cpu_coalescing_storebuffer                                    |
// | Purpose  : Coalescing store buffer between CPU store path and D-cache.   |
// |            Circular FIFO of tagged byte-masked entries, youngest-wins    |
// |            load forwarding, oldest-first drain over valid/ready.         |
// | Option   : define CPU_STOREBUFFER_COALESCE_EN to merge stores into the   |
// |            youngest non-head entry with a matching tag.                  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module cpu_coalescing_storebuffer #(
  parameter int DEPTH      = 4,
  parameter int TAG_WIDTH  = 16,
  parameter int DATA_WIDTH = 32,
  localparam int NB     = DATA_WIDTH / 8,
  localparam int OFF_W  = (NB > 1) ? $clog2(NB) : 1,
  localparam int SIZE_W = $clog2(OFF_W + 1),
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = PTR_W + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  push_valid,
  output logic                  push_ready,
  input  logic [TAG_WIDTH-1:0]  push_tag,
  input  logic [OFF_W-1:0]      push_offset,
  input  logic [SIZE_W-1:0]     push_size,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic [TAG_WIDTH-1:0]  lookup_tag,
  output logic [NB-1:0]         hit_mask,
  output logic [DATA_WIDTH-1:0] hit_data,
  output logic                  drain_valid,
  input  logic                  drain_ready,
  output logic [TAG_WIDTH-1:0]  drain_tag,
  output logic [NB-1:0]         drain_mask,
  output logic [DATA_WIDTH-1:0] drain_data,
  output logic [CNT_W-1:0]      count,
  output logic                  empty,
  output logic                  full
);

  logic [TAG_WIDTH-1:0]  r_tag  [DEPTH];
  logic [NB-1:0]         r_mask [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;

  logic                  w_empty;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_alloc;
  logic                  w_merge;
  logic [PTR_W-1:0]      w_merge_idx;
  logic [SIZE_W-1:0]     w_size;
  logic [OFF_W-1:0]      w_low;
  logic [OFF_W-1:0]      w_off;
  logic [NB-1:0]         w_push_mask;
  logic [DATA_WIDTH-1:0] w_push_bits;
  logic [DATA_WIDTH-1:0] w_push_wdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_push  = push_valid && !w_full;
  assign w_pop   = drain_ready && !w_empty;
  assign w_alloc = w_push && !w_merge;

  assign count       = r_count;
  assign empty       = w_empty;
  assign full        = w_full;
  assign push_ready  = !w_full;
  assign drain_valid = !w_empty;

  // Stale slots keep old contents after retiring, so gate the head view.
  assign drain_tag  = w_empty ? '0 : r_tag[r_rd_ptr];
  assign drain_mask = w_empty ? '0 : r_mask[r_rd_ptr];
  assign drain_data = w_empty ? '0 : r_data[r_rd_ptr];

  // Push decode: align the offset to the access size and place the LSB-aligned
  // data at that byte lane; bytes outside the access are forced to zero.
  always_comb begin
    w_size      = (push_size > SIZE_W'(OFF_W)) ? SIZE_W'(OFF_W) : push_size;
    w_low       = OFF_W'((32'd1 << w_size) - 32'd1);
    w_off       = push_offset & ~w_low;
    w_push_mask = '0;
    w_push_bits = '0;
    for (int b = 0; b < NB; b++) begin
      w_push_mask[b] = (32'(b) >= 32'(w_off)) &&
                       (32'(b) < (32'(w_off) + (32'd1 << w_size)));
      w_push_bits[8*b +: 8] = {8{w_push_mask[b]}};
    end
    w_push_wdata = (push_data << {w_off, 3'b000}) & w_push_bits;
  end

`ifdef CPU_STOREBUFFER_COALESCE_EN
  // Youngest occupied non-head slot with a matching tag; age 0 is the head.
  always_comb begin
    w_merge     = 1'b0;
    w_merge_idx = '0;
    for (int a = 1; a < DEPTH; a++) begin
      if ((CNT_W'(a) < r_count) && (r_tag[r_rd_ptr + PTR_W'(a)] == push_tag)) begin
        w_merge     = 1'b1;
        w_merge_idx = r_rd_ptr + PTR_W'(a);
      end
    end
  end
`else
  assign w_merge     = 1'b0;
  assign w_merge_idx = '0;
`endif

  // Forwarding scans oldest to youngest so the youngest holder of a byte wins.
  always_comb begin
    hit_mask = '0;
    hit_data = '0;
    for (int a = 0; a < DEPTH; a++) begin
      for (int b = 0; b < NB; b++) begin
        if ((CNT_W'(a) < r_count) &&
            (r_tag[r_rd_ptr + PTR_W'(a)] == lookup_tag) &&
            r_mask[r_rd_ptr + PTR_W'(a)][b]) begin
          hit_mask[b]         = 1'b1;
          hit_data[8*b +: 8]  = r_data[r_rd_ptr + PTR_W'(a)][8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_tag[i]  <= '0;
        r_mask[i] <= '0;
        r_data[i] <= '0;
      end
    end else begin
      if (w_push && w_merge) begin
        r_mask[w_merge_idx] <= r_mask[w_merge_idx] | w_push_mask;
        r_data[w_merge_idx] <= (r_data[w_merge_idx] & ~w_push_bits) | w_push_wdata;
      end
      if (w_alloc) begin
        r_tag[r_wr_ptr]  <= push_tag;
        r_mask[r_wr_ptr] <= w_push_mask;
        r_data[r_wr_ptr] <= w_push_wdata;
        r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_alloc && !w_pop) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_alloc && w_pop) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpu_coalescing_storebuffer.sv
// +--------------------------------------------------------------------------+
// | Module   : tb_cpu_coalescing_storebuffer                                 |
// | Purpose  : Directed self-checking bench for cpu_coalescing_storebuffer.  |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_cpu_coalescing_storebuffer;

  logic        clock;
  logic        reset;
  logic        push_valid;
  logic        push_ready;
  logic [15:0] push_tag;
  logic [1:0]  push_offset;
  logic [1:0]  push_size;
  logic [31:0] push_data;
  logic [15:0] lookup_tag;
  logic [3:0]  hit_mask;
  logic [31:0] hit_data;
  logic        drain_valid;
  logic        drain_ready;
  logic [15:0] drain_tag;
  logic [3:0]  drain_mask;
  logic [31:0] drain_data;
  logic [2:0]  count;
  logic        empty;
  logic        full;

  int n_vec = 0;
  int n_err = 0;

  cpu_coalescing_storebuffer #(
    .DEPTH(4), .TAG_WIDTH(16), .DATA_WIDTH(32)
  ) dut (
    .clock(clock), .reset(reset),
    .push_valid(push_valid), .push_ready(push_ready), .push_tag(push_tag),
    .push_offset(push_offset), .push_size(push_size), .push_data(push_data),
    .lookup_tag(lookup_tag), .hit_mask(hit_mask), .hit_data(hit_data),
    .drain_valid(drain_valid), .drain_ready(drain_ready), .drain_tag(drain_tag),
    .drain_mask(drain_mask), .drain_data(drain_data),
    .count(count), .empty(empty), .full(full)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Stimulus tasks start and end 1 time unit after a rising edge.
  task automatic do_push(input logic [15:0] tag, input logic [1:0] off,
                         input logic [1:0] size, input logic [31:0] data);
    push_valid = 1'b1; push_tag = tag; push_offset = off; push_size = size; push_data = data;
    @(posedge clock); #1;
    push_valid = 1'b0;
  endtask

  task automatic do_drain();
    drain_ready = 1'b1;
    @(posedge clock); #1;
    drain_ready = 1'b0;
  endtask

  task automatic drain_all(input string name);
    for (int k = 0; k < 6 && drain_valid; k++) do_drain();
    n_vec++;
    if (empty !== 1'b1) begin
      $display("FAIL %s_drain_all empty got %b want 1", name, empty); n_err++;
    end
  endtask

  task automatic test_reset();
    n_vec++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || push_ready !== 1'b1 ||
        drain_valid !== 1'b0 || drain_mask !== 4'h0 || drain_data !== 32'h0 ||
        hit_mask !== 4'h0 || hit_data !== 32'h0) begin
      $display("FAIL reset_state cnt=%0d e=%b f=%b pr=%b dv=%b dm=%h dd=%h hm=%h hd=%h want 0 1 0 1 0 0 0 0 0",
               count, empty, full, push_ready, drain_valid, drain_mask, drain_data, hit_mask, hit_data);
      n_err++;
    end
  endtask

  task automatic test_async_reset();
    do_push(16'd1, 2'd0, 2'd2, 32'h0101_0101);
    do_push(16'd2, 2'd0, 2'd2, 32'h0202_0202);
    lookup_tag = 16'd1;
    push_valid = 1'b1; push_tag = 16'd3; push_offset = 2'd0; push_size = 2'd2; push_data = 32'h3;
    drain_ready = 1'b1;
    #2 reset = 1'b0;
    #1;
    n_vec++;
    if (count !== 3'd0 || empty !== 1'b1 || full !== 1'b0 || drain_valid !== 1'b0 || hit_mask !== 4'h0) begin
      $display("FAIL async_reset cnt=%0d e=%b f=%b dv=%b hm=%h want 0 1 0 0 0",
               count, empty, full, drain_valid, hit_mask);
      n_err++;
    end
    push_valid = 1'b0; drain_ready = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    do_drain();
    n_vec++;
    if (count !== 3'd0 || drain_valid !== 1'b0) begin
      $display("FAIL drain_when_empty cnt=%0d dv=%b want 0 0", count, drain_valid); n_err++;
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) do_push(16'd10 + 16'(i), 2'd0, 2'd2, 32'hA000_0000 + 32'(i));
    n_vec++;
    if (full !== 1'b1 || push_ready !== 1'b0 || count !== 3'd4) begin
      $display("FAIL fill_full f=%b pr=%b cnt=%0d want 1 0 4", full, push_ready, count); n_err++;
    end
    do_push(16'd14, 2'd0, 2'd2, 32'hDEAD_BEEF);
    n_vec++;
    if (count !== 3'd4) begin
      $display("FAIL fill_drop cnt=%0d want 4", count); n_err++;
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (drain_tag !== 16'd10 + 16'(i) || drain_data !== 32'hA000_0000 + 32'(i) || drain_mask !== 4'hF) begin
        $display("FAIL fill_order[%0d] tag=%0d data=%h mask=%h want %0d %h f",
                 i, drain_tag, drain_data, drain_mask, 10 + i, 32'hA000_0000 + 32'(i));
        n_err++;
      end
      do_drain();
    end
    n_vec++;
    if (empty !== 1'b1) begin
      $display("FAIL fill_empty got %b want 1", empty); n_err++;
    end
  endtask

  task automatic test_forward();
    do_push(16'd10, 2'd0, 2'd2, 32'h1122_3344);
    do_push(16'd10, 2'd2, 2'd1, 32'h0000_5566);
    do_push(16'd10, 2'd0, 2'd0, 32'h0000_00AA);
    lookup_tag = 16'd10; #1;
    n_vec++;
    if (hit_mask !== 4'hF || hit_data !== 32'h5566_33AA) begin
      $display("FAIL fwd_hit mask=%h data=%h want f 556633aa", hit_mask, hit_data); n_err++;
    end
`ifndef CPU_STOREBUFFER_COALESCE_EN
    n_vec++;
    if (count !== 3'd3) begin
      $display("FAIL fwd_count got %0d want 3", count); n_err++;
    end
`endif
    lookup_tag = 16'd99; #1;
    n_vec++;
    if (hit_mask !== 4'h0 || hit_data !== 32'h0) begin
      $display("FAIL fwd_miss mask=%h data=%h want 0 0", hit_mask, hit_data); n_err++;
    end
    n_vec++;
    if (drain_tag !== 16'd10 || drain_mask !== 4'hF || drain_data !== 32'h1122_3344) begin
      $display("FAIL fwd_head tag=%0d mask=%h data=%h want 10 f 11223344", drain_tag, drain_mask, drain_data);
      n_err++;
    end
    drain_all("fwd");
  endtask

  task automatic test_align();
    do_push(16'd60, 2'd3, 2'd1, 32'h0000_ABCD);
    do_push(16'd61, 2'd2, 2'd0, 32'h1234_5677);
    n_vec++;
    if (drain_tag !== 16'd60 || drain_mask !== 4'hC || drain_data !== 32'hABCD_0000) begin
      $display("FAIL align_half tag=%0d mask=%h data=%h want 60 c abcd0000", drain_tag, drain_mask, drain_data);
      n_err++;
    end
    do_drain();
    n_vec++;
    if (drain_tag !== 16'd61 || drain_mask !== 4'h4 || drain_data !== 32'h0077_0000) begin
      $display("FAIL align_byte tag=%0d mask=%h data=%h want 61 4 00770000", drain_tag, drain_mask, drain_data);
      n_err++;
    end
    drain_all("align");
  endtask

  task automatic test_coalesce();
    do_push(16'd20, 2'd0, 2'd2, 32'h2020_2020);
    do_push(16'd30, 2'd1, 2'd0, 32'h0000_00BB);
    do_push(16'd30, 2'd3, 2'd0, 32'h0000_00CC);
    lookup_tag = 16'd30; #1;
    n_vec++;
    if (hit_mask !== 4'hA || hit_data !== 32'hCC00_BB00) begin
      $display("FAIL coal_fwd mask=%h data=%h want a cc00bb00", hit_mask, hit_data); n_err++;
    end
`ifdef CPU_STOREBUFFER_COALESCE_EN
    n_vec++;
    if (count !== 3'd2) begin
      $display("FAIL coal_count got %0d want 2", count); n_err++;
    end
    do_drain();
    n_vec++;
    if (drain_tag !== 16'd30 || drain_mask !== 4'hA || drain_data !== 32'hCC00_BB00) begin
      $display("FAIL coal_entry tag=%0d mask=%h data=%h want 30 a cc00bb00", drain_tag, drain_mask, drain_data);
      n_err++;
    end
`else
    n_vec++;
    if (count !== 3'd3) begin
      $display("FAIL coal_count got %0d want 3", count); n_err++;
    end
    do_drain();
    n_vec++;
    if (drain_tag !== 16'd30 || drain_mask !== 4'h2 || drain_data !== 32'h0000_BB00) begin
      $display("FAIL coal_entry1 tag=%0d mask=%h data=%h want 30 2 0000bb00", drain_tag, drain_mask, drain_data);
      n_err++;
    end
    do_drain();
    n_vec++;
    if (drain_tag !== 16'd30 || drain_mask !== 4'h8 || drain_data !== 32'hCC00_0000) begin
      $display("FAIL coal_entry2 tag=%0d mask=%h data=%h want 30 8 cc000000", drain_tag, drain_mask, drain_data);
      n_err++;
    end
`endif
    drain_all("coal");
  endtask

  task automatic test_head_protect();
    do_push(16'd40, 2'd0, 2'd2, 32'h0102_0304);
    do_push(16'd40, 2'd0, 2'd0, 32'h0000_00EE);
    n_vec++;
    if (count !== 3'd2) begin
      $display("FAIL head_count got %0d want 2", count); n_err++;
    end
    for (int c = 0; c < 3; c++) begin
      n_vec++;
      if (drain_tag !== 16'd40 || drain_mask !== 4'hF || drain_data !== 32'h0102_0304) begin
        $display("FAIL head_stall[%0d] tag=%0d mask=%h data=%h want 40 f 01020304",
                 c, drain_tag, drain_mask, drain_data);
        n_err++;
      end
      @(posedge clock); #1;
    end
    lookup_tag = 16'd40; #1;
    n_vec++;
    if (hit_mask !== 4'hF || hit_data !== 32'h0102_03EE) begin
      $display("FAIL head_fwd mask=%h data=%h want f 010203ee", hit_mask, hit_data); n_err++;
    end
    drain_all("head");
  endtask

  task automatic test_back_to_back();
    do_push(16'd50, 2'd0, 2'd2, 32'h0000_0050);
    do_push(16'd51, 2'd0, 2'd2, 32'h0000_0051);
    push_valid = 1'b1; push_tag = 16'd52; push_offset = 2'd0; push_size = 2'd2; push_data = 32'h52;
    drain_ready = 1'b1;
    @(posedge clock); #1;
    push_valid = 1'b0; drain_ready = 1'b0;
    n_vec++;
    if (count !== 3'd2 || drain_tag !== 16'd51) begin
      $display("FAIL simul_push_pop cnt=%0d tag=%0d want 2 51", count, drain_tag); n_err++;
    end
    do_drain();
    n_vec++;
    if (drain_tag !== 16'd52 || drain_data !== 32'h0000_0052) begin
      $display("FAIL simul_next tag=%0d data=%h want 52 00000052", drain_tag, drain_data); n_err++;
    end
    drain_all("simul");
    for (int i = 0; i < 4; i++) do_push(16'd70 + 16'(i), 2'd0, 2'd2, 32'h70 + 32'(i));
    push_valid = 1'b1; push_tag = 16'd80; push_data = 32'h80; drain_ready = 1'b1;
    #1;
    n_vec++;
    if (push_ready !== 1'b0) begin
      $display("FAIL full_gate push_ready got %b want 0", push_ready); n_err++;
    end
    @(posedge clock); #1;
    push_valid = 1'b0; drain_ready = 1'b0;
    n_vec++;
    if (count !== 3'd3 || drain_tag !== 16'd71) begin
      $display("FAIL full_pop cnt=%0d tag=%0d want 3 71", count, drain_tag); n_err++;
    end
    lookup_tag = 16'd80; #1;
    n_vec++;
    if (hit_mask !== 4'h0) begin
      $display("FAIL full_drop_fwd mask=%h want 0", hit_mask); n_err++;
    end
    drain_all("full");
  endtask

  initial begin
    reset = 1'b0; push_valid = 1'b0; push_tag = '0; push_offset = '0; push_size = '0;
    push_data = '0; lookup_tag = '0; drain_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    test_async_reset();
    test_fill();
    test_forward();
    test_align();
    test_coalesce();
    test_head_protect();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
